// File: rtl/inp_capture_pkg.sv
// ============================================================================
// Module   : inp_pkg
// Brief    : Shared FSM state type and default sizing for the input capture.
// Revision : 1.0
// ============================================================================
`default_nettype none

package inp_pkg;

   localparam int c_DEF_WIDTH      = 16;
   localparam int c_DEF_DEB_CYCLES = 1000000;
   localparam int c_DEF_CNT_W      = 20;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_REL   = 2'd1,
      ST_WAIT_PRESS = 2'd2,
      ST_HOLD       = 2'd3
   } state_t;

   // The operator LED is lit only while a confirm is still outstanding.
   function automatic logic is_waiting(input state_t s);
      return (s == ST_WAIT_REL) || (s == ST_WAIT_PRESS);
   endfunction

endpackage

`default_nettype wire

// File: rtl/inp_capture_if.sv
// ============================================================================
// Module   : inp_capture_if
// Brief    : Processor-side IN handshake (req/done) plus latched operand.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface inp_capture_if
   import inp_pkg::*;
#(
   parameter int WIDTH = c_DEF_WIDTH
);

   logic             req;
   logic [WIDTH-1:0] inpval;
   logic             done;
   logic             waiting;

   modport master (
      output req,
      input  inpval,
      input  done,
      input  waiting
   );

   modport slave (
      input  req,
      output inpval,
      output done,
      output waiting
   );

endinterface

`default_nettype wire

// File: rtl/inp_capture_debounce.sv
// ============================================================================
// Module   : inp_debounce
// Brief    : Two-flop synchroniser plus shared-counter debouncer for a vector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inp_debounce #(
   parameter int WIDTH      = 1,
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = 20
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] db_o
);

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] db_q;
   logic [WIDTH-1:0] db_d;
   logic [WIDTH-1:0] tgt_q;
   logic [WIDTH-1:0] tgt_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         tgt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
      end
   end

   // tgt_q remembers which value is being counted toward, so a vector that
   // moves again mid-count restarts from one instead of inheriting the count.
   // The level flips on the DEB_CYCLES-th consecutive differing sample.
   always_comb begin
      db_d  = db_q;
      tgt_d = tgt_q;
      cnt_d = cnt_q;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if ((cnt_q == '0) || (sync2_q != tgt_q)) begin
         tgt_d = sync2_q;
         cnt_d = CNT_W'(1);
      end else if (cnt_q == c_LAST) begin
         db_d  = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign db_o = db_q;

endmodule

`default_nettype wire

// File: rtl/inp_capture.sv
// ============================================================================
// Module   : inp_capture
// Brief    : Debounced switch/button capture serving the processor IN request.
//            INP_CAPTURE_ECHO_EN adds a live registered echo of the switches.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inp_capture
   import inp_pkg::*;
#(
   parameter int WIDTH      = c_DEF_WIDTH,
   parameter int DEB_CYCLES = c_DEF_DEB_CYCLES,
   parameter int CNT_W      = c_DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   input  logic             n_btn_raw,
   inp_capture_if.slave     bus,
   output logic [WIDTH-1:0] sw_echo
);

   logic [WIDTH-1:0] w_sw_db;
   logic [0:0]       w_btn_act;
   logic [0:0]       w_btn_db;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] inpval_q;
   logic [WIDTH-1:0] inpval_d;
   logic             done_q;
   logic             done_d;
   logic             waiting_q;
   logic             waiting_d;

   // Inverted ahead of the synchroniser so a reset chain reads "released".
   assign w_btn_act = ~n_btn_raw;

   inp_debounce #(
      .WIDTH      (1),
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_btn_deb (
      .clock (clock),
      .reset (reset),
      .raw_i (w_btn_act),
      .db_o  (w_btn_db)
   );

   inp_debounce #(
      .WIDTH      (WIDTH),
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_sw_deb (
      .clock (clock),
      .reset (reset),
      .raw_i (sw_raw),
      .db_o  (w_sw_db)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         inpval_q  <= '0;
         done_q    <= 1'b0;
         waiting_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         inpval_q  <= inpval_d;
         done_q    <= done_d;
         waiting_q <= waiting_d;
      end
   end

   // A press already debounced when req rises must be released first, so
   // one physical press can never satisfy two requests.
   always_comb begin
      state_d  = state_q;
      inpval_d = inpval_q;
      done_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               state_d = w_btn_db[0] ? ST_WAIT_REL : ST_WAIT_PRESS;
            end
         end
         ST_WAIT_REL: begin
            if (!bus.req) begin
               state_d = ST_IDLE;
            end else if (!w_btn_db[0]) begin
               state_d = ST_WAIT_PRESS;
            end
         end
         ST_WAIT_PRESS: begin
            if (!bus.req) begin
               state_d = ST_IDLE;
            end else if (w_btn_db[0]) begin
               inpval_d = w_sw_db;
               done_d   = 1'b1;
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!bus.req) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      waiting_d = is_waiting(state_d);
   end

   assign bus.inpval  = inpval_q;
   assign bus.done    = done_q;
   assign bus.waiting = waiting_q;

`ifdef INP_CAPTURE_ECHO_EN
   logic [WIDTH-1:0] echo_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         echo_q <= '0;
      end else begin
         echo_q <= w_sw_db;
      end
   end

   assign sw_echo = echo_q;
`else
   assign sw_echo = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inp_capture.sv
// ============================================================================
// Module   : tb_inp_capture
// Brief    : Self-checking bench for inp_capture with DEB_CYCLES=4; expected
//            sw_echo follows INP_CAPTURE_ECHO_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inp_capture;

   localparam int DEB = 4;

`ifdef INP_CAPTURE_ECHO_EN
   localparam bit c_ECHO = 1'b1;
`else
   localparam bit c_ECHO = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic [15:0] sw_raw;
   logic        n_btn_raw;
   logic [15:0] sw_echo;

   int checks   = 0;
   int failures = 0;

   inp_capture_if #(.WIDTH(16)) bus ();

   inp_capture #(
      .WIDTH      (16),
      .DEB_CYCLES (DEB),
      .CNT_W      (4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .sw_raw    (sw_raw),
      .n_btn_raw (n_btn_raw),
      .bus       (bus.slave),
      .sw_echo   (sw_echo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: debounced level = value seen on DEB consecutive
   // synchronised samples; the FSM follows the operator-level rules.
   logic [15:0] q_sw[$];
   logic        q_btn[$];
   logic [15:0] sw_run_val;
   int          sw_run_len;
   logic        btn_run_val;
   int          btn_run_len;
   logic [15:0] m_sw_db, m_inpval, m_echo;
   logic        m_btn_db, m_done, m_waiting;
   int          m_state;   // 0 idle, 1 wait release, 2 wait press, 3 hold

   task automatic model_reset();
      q_sw.delete();
      q_btn.delete();
      sw_run_val = '0; sw_run_len = 0;
      btn_run_val = 1'b0; btn_run_len = 0;
      m_sw_db = '0; m_inpval = '0; m_echo = '0;
      m_btn_db = 1'b0; m_done = 1'b0; m_waiting = 1'b0;
      m_state = 0;
   endtask

   task automatic model_edge();
      logic [15:0] sw_s;
      logic        btn_s;
      logic [15:0] nsw;
      logic        nbtn;
      q_sw.push_back(sw_raw);
      q_btn.push_back(~n_btn_raw);
      sw_s  = (q_sw.size() >= 3) ? q_sw[q_sw.size()-3] : 16'h0;
      btn_s = (q_btn.size() >= 3) ? q_btn[q_btn.size()-3] : 1'b0;
      if (q_sw.size() > 3) void'(q_sw.pop_front());
      if (q_btn.size() > 3) void'(q_btn.pop_front());
      if (sw_run_len > 0 && sw_s == sw_run_val) sw_run_len++;
      else begin sw_run_val = sw_s; sw_run_len = 1; end
      if (btn_run_len > 0 && btn_s == btn_run_val) btn_run_len++;
      else begin btn_run_val = btn_s; btn_run_len = 1; end
      nsw  = (sw_run_len >= DEB && sw_run_val != m_sw_db) ? sw_run_val : m_sw_db;
      nbtn = (btn_run_len >= DEB && btn_run_val != m_btn_db) ? btn_run_val : m_btn_db;
      m_echo = c_ECHO ? m_sw_db : 16'h0;
      m_done = 1'b0;
      case (m_state)
         0: if (bus.req) m_state = m_btn_db ? 1 : 2;
         1: if (!bus.req) m_state = 0; else if (!m_btn_db) m_state = 2;
         2: if (!bus.req) m_state = 0;
            else if (m_btn_db) begin m_inpval = m_sw_db; m_done = 1'b1; m_state = 3; end
         default: if (!bus.req) m_state = 0;
      endcase
      m_waiting = (m_state == 1) || (m_state == 2);
      m_sw_db  = nsw;
      m_btn_db = nbtn;
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic test_reset();
      bit got;
      reset = 1'b1; bus.req = 1'b0; n_btn_raw = 1'b1; sw_raw = 16'h0;
      repeat (2) @(negedge clock);
      checks++;
      if ({bus.done, bus.waiting, bus.inpval, sw_echo} !== 34'h0) begin
         failures++;
         $display("FAIL reset_initial: got done=%b waiting=%b inpval=%h echo=%h, want all zero",
                  bus.done, bus.waiting, bus.inpval, sw_echo);
      end
      reset = 1'b0;
      model_reset();
      sw_raw = 16'h1234;
      repeat (8) tick();
      bus.req = 1'b1;
      repeat (2) tick();
      n_btn_raw = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (bus.done) got = 1'b1;
      end
      checks++;
      if (!got || bus.inpval !== 16'h1234) begin
         failures++;
         $display("FAIL reset_setup: got done_seen=%b inpval=%h, want done_seen=1 inpval=1234", got, bus.inpval);
      end
      tick();
      n_btn_raw = 1'b1;
      tick();
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({bus.done, bus.waiting, bus.inpval, sw_echo} !== 34'h0) begin
         failures++;
         $display("FAIL reset_async: got done=%b waiting=%b inpval=%h echo=%h, want all zero before edge",
                  bus.done, bus.waiting, bus.inpval, sw_echo);
      end
      model_reset();
      bus.req = 1'b1;
      #1 reset = 1'b0;
      tick();
      checks++;
      if (bus.waiting !== 1'b1 || m_waiting !== 1'b1) begin
         failures++;
         $display("FAIL reset_to_idle: got waiting=%b model=%b, want 1 (IDLE took req)", bus.waiting, m_waiting);
      end
      bus.req = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_capture();
      int first = -1;
      int nd = 0;
      sw_raw = 16'hBEEF;
      repeat (8) tick();
      bus.req = 1'b1;
      repeat (2) tick();
      checks++;
      if (bus.waiting !== 1'b1) begin
         failures++;
         $display("FAIL capture_waiting: got waiting=%b, want 1", bus.waiting);
      end
      n_btn_raw = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         checks++;
         if ({bus.done, bus.waiting, bus.inpval, sw_echo} !== {m_done, m_waiting, m_inpval, m_echo}) begin
            failures++;
            $display("FAIL capture_model: got done=%b waiting=%b inpval=%h echo=%h, want done=%b waiting=%b inpval=%h echo=%h",
                     bus.done, bus.waiting, bus.inpval, sw_echo, m_done, m_waiting, m_inpval, m_echo);
         end
         if (bus.done) begin nd++; if (first < 0) first = i; end
      end
      checks++;
      if (first != DEB + 3 || nd != 1) begin
         failures++;
         $display("FAIL capture_latency: got first_done_tick=%0d pulses=%0d, want %0d and 1", first, nd, DEB + 3);
      end
      checks++;
      if (bus.inpval !== 16'hBEEF || bus.waiting !== 1'b0) begin
         failures++;
         $display("FAIL capture_value: got inpval=%h waiting=%b, want beef and 0", bus.inpval, bus.waiting);
      end
      n_btn_raw = 1'b1; bus.req = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_bounce();
      int nd = 0;
      sw_raw = 16'h5A5A;
      repeat (8) tick();
      bus.req = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         n_btn_raw = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
         tick();
         if (bus.done) nd++;
      end
      checks++;
      if (nd != 0) begin
         failures++;
         $display("FAIL bounce_quiet: got %0d done pulses during bounce, want 0", nd);
      end
      n_btn_raw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if ({bus.done, bus.waiting, bus.inpval} !== {m_done, m_waiting, m_inpval}) begin
            failures++;
            $display("FAIL bounce_model: got done=%b waiting=%b inpval=%h, want done=%b waiting=%b inpval=%h",
                     bus.done, bus.waiting, bus.inpval, m_done, m_waiting, m_inpval);
         end
         if (bus.done) nd++;
      end
      checks++;
      if (nd != 1 || bus.inpval !== 16'h5A5A) begin
         failures++;
         $display("FAIL bounce_capture: got pulses=%0d inpval=%h, want 1 and 5a5a", nd, bus.inpval);
      end
      n_btn_raw = 1'b1; bus.req = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_held();
      int nd = 0;
      n_btn_raw = 1'b0; sw_raw = 16'h00A5;
      repeat (8) tick();
      bus.req = 1'b1;
      repeat (10) begin tick(); if (bus.done) nd++; end
      checks++;
      if (nd != 0 || bus.waiting !== 1'b1) begin
         failures++;
         $display("FAIL held_no_confirm: got pulses=%0d waiting=%b, want 0 and 1", nd, bus.waiting);
      end
      n_btn_raw = 1'b1;
      repeat (8) begin tick(); if (bus.done) nd++; end
      n_btn_raw = 1'b0;
      repeat (12) begin
         tick();
         checks++;
         if ({bus.done, bus.waiting, bus.inpval} !== {m_done, m_waiting, m_inpval}) begin
            failures++;
            $display("FAIL held_model: got done=%b waiting=%b inpval=%h, want done=%b waiting=%b inpval=%h",
                     bus.done, bus.waiting, bus.inpval, m_done, m_waiting, m_inpval);
         end
         if (bus.done) nd++;
      end
      checks++;
      if (nd != 1 || bus.inpval !== 16'h00A5) begin
         failures++;
         $display("FAIL held_capture: got pulses=%0d inpval=%h, want 1 and 00a5", nd, bus.inpval);
      end
      n_btn_raw = 1'b1; bus.req = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_abort();
      int nd = 0;
      sw_raw = 16'h7777;
      repeat (8) tick();
      bus.req = 1'b1;
      repeat (3) tick();
      bus.req = 1'b0;
      n_btn_raw = 1'b0;
      repeat (10) begin tick(); if (bus.done) nd++; end
      checks++;
      if (nd != 0 || bus.inpval !== 16'h00A5 || bus.waiting !== 1'b0) begin
         failures++;
         $display("FAIL abort: got pulses=%0d inpval=%h waiting=%b, want 0, 00a5, 0", nd, bus.inpval, bus.waiting);
      end
      n_btn_raw = 1'b1;
      repeat (8) tick();
      bus.req = 1'b1;
      tick();
      checks++;
      if (bus.waiting !== 1'b1 || m_waiting !== 1'b1) begin
         failures++;
         $display("FAIL abort_idle: got waiting=%b model=%b, want 1", bus.waiting, m_waiting);
      end
      bus.req = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_echo();
      sw_raw = 16'h0000;
      repeat (8) tick();
      sw_raw = 16'h0F0F;
      for (int i = 1; i <= DEB + 3; i++) begin
         tick();
         checks++;
         if (sw_echo !== m_echo) begin
            failures++;
            $display("FAIL echo_model: tick %0d got echo=%h, want %h", i, sw_echo, m_echo);
         end
      end
      checks++;
      if (sw_echo !== (c_ECHO ? 16'h0F0F : 16'h0000)) begin
         failures++;
         $display("FAIL echo_final: got echo=%h, want %h", sw_echo, c_ECHO ? 16'h0F0F : 16'h0000);
      end
   endtask

   task automatic test_random();
      logic [15:0] v;
      bit got;
      for (int it = 0; it < 8; it++) begin
         v = 16'($urandom);
         sw_raw = 16'($urandom);
         repeat (2) tick();
         sw_raw = v;
         repeat (8) tick();
         bus.req = 1'b1;
         repeat ($urandom_range(1, 5)) tick();
         n_btn_raw = 1'b0;
         got = 1'b0;
         for (int i = 0; i < 15 && !got; i++) begin
            tick();
            // Odd runs move the switches so they settle on the latching edge.
            if (i == 0 && (it % 2) == 1) sw_raw = ~v;
            checks++;
            if ({bus.done, bus.waiting, bus.inpval, sw_echo} !== {m_done, m_waiting, m_inpval, m_echo}) begin
               failures++;
               $display("FAIL random_model: it %0d got done=%b waiting=%b inpval=%h echo=%h, want done=%b waiting=%b inpval=%h echo=%h",
                        it, bus.done, bus.waiting, bus.inpval, sw_echo, m_done, m_waiting, m_inpval, m_echo);
            end
            if (bus.done) got = 1'b1;
         end
         checks++;
         if (!got || bus.inpval !== v) begin
            failures++;
            $display("FAIL random_capture: it %0d got done_seen=%b inpval=%h, want 1 and %h", it, got, bus.inpval, v);
         end
         n_btn_raw = 1'b1; bus.req = 1'b0;
         repeat (6) tick();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      model_reset();
      test_reset();
      test_capture();
      test_bounce();
      test_held();
      test_abort();
      test_echo();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
